// File: rtl/ps2_mouse_pkg.sv
// Shared definitions for the PS/2 mouse receiver and cursor tracker:
// frame FSM encoding, byte-0 bit positions, default screen size, clamp helper.
package ps2_mouse_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_e;

    localparam int B0_LEFT   = 0;
    localparam int B0_RIGHT  = 1;
    localparam int B0_MIDDLE = 2;
    localparam int B0_SYNC   = 3;
    localparam int B0_XSIGN  = 4;
    localparam int B0_YSIGN  = 5;
    localparam int B0_XOVF   = 6;
    localparam int B0_YOVF   = 7;

    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;

    // Only the header bits the cursor path consumes are kept.
    typedef struct packed {
        logic left;
        logic x_sign;
        logic y_sign;
        logic x_ovf;
        logic y_ovf;
    } pkt_hdr_t;

    function automatic logic [9:0] clamp_axis(input logic signed [11:0] v, input int lim);
        if (v < 12'sd0)
            return '0;
        else if (int'(v) > lim - 1)
            return 10'(lim - 1);
        else
            return v[9:0];
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host byte receiver: pad synchronisers, ps2_clk glitch filter,
// 11-bit frame FSM. Optional inactivity watchdog under PS2_MOUSE_WATCHDOG_EN.
module ps2_rx_frame
    import ps2_mouse_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_sync, dat_sync;
    logic [FW-1:0] flt_cnt;
    logic          clk_flt;
    logic          fall;
    logic          din;

    rx_state_e     state, state_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n;

    // Lines idle high, so reset the synchronisers to 1 to avoid a false edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
        end
    end

    // A level change is accepted after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            flt_cnt <= '0;
            clk_flt <= 1'b1;
            fall    <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_sync[1] == clk_flt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                flt_cnt <= '0;
                clk_flt <= clk_sync[1];
                fall    <= clk_flt;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    assign din     = dat_sync[1];
    assign rx_byte = shreg;

`ifdef PS2_MOUSE_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd_cnt;
    logic          wd_hit;

    assign wd_hit = (state != IDLE) && !fall && (wd_cnt == WW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || fall || state == IDLE || wd_hit)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 1'b1;
    end
`else
    logic wd_hit;
    assign wd_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        rx_valid  = 1'b0;
        rx_err    = 1'b0;
        if (wd_hit) begin
            state_n = IDLE;
            rx_err  = 1'b1;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    if (!din) begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                    end
                end
                DATA: begin
                    shreg_n   = {din, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        state_n = PARITY;
                end
                PARITY: begin
                    // Odd parity: the parity bit is the complement of the data XOR.
                    if (din == ~^shreg) begin
                        state_n = STOP;
                    end else begin
                        state_n = IDLE;
                        rx_err  = 1'b1;
                    end
                end
                STOP: begin
                    state_n = IDLE;
                    if (din)
                        rx_valid = 1'b1;
                    else
                        rx_err = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ps2_mouse_cursor.sv
// PS/2 mouse packet assembler and clamped cursor tracker.
// Optional receiver watchdog: define PS2_MOUSE_WATCHDOG_EN.
module ps2_mouse_cursor
    import ps2_mouse_pkg::*;
#(
    parameter int SCREEN_W       = DEF_SCREEN_W,
    parameter int SCREEN_H       = DEF_SCREEN_H,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [9:0] mouseX,
    output logic [9:0] mouseY,
    output logic       mouseBotton,
    output logic       click,
    output logic       packet_valid,
    output logic       frame_error
);

    logic [7:0] rx_byte;
    logic       rx_valid, rx_err;

    ps2_rx_frame #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk     (clk),
        .reset   (reset),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .rx_byte (rx_byte),
        .rx_valid(rx_valid),
        .rx_err  (rx_err)
    );

    logic [1:0]         byte_idx;
    pkt_hdr_t           hdr;
    logic [7:0]         dx_byte;
    logic signed [11:0] dx, dy, nx, ny;

    // Byte 2 is consumed directly off the receiver, so the update lands one
    // clock after its stop bit without an extra holding register.
    always_comb begin
        dx = hdr.x_ovf ? 12'sd0 : $signed({{4{hdr.x_sign}}, dx_byte});
        dy = hdr.y_ovf ? 12'sd0 : $signed({{4{hdr.y_sign}}, rx_byte});
        nx = $signed(12'(mouseX)) + dx;
        ny = $signed(12'(mouseY)) - dy;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_idx     <= '0;
            hdr          <= '0;
            dx_byte      <= '0;
            mouseX       <= 10'(SCREEN_W / 2);
            mouseY       <= 10'(SCREEN_H / 2);
            mouseBotton  <= 1'b0;
            click        <= 1'b0;
            packet_valid <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            packet_valid <= 1'b0;
            click        <= 1'b0;
            frame_error  <= rx_err;
            if (rx_err) begin
                byte_idx <= '0;
            end else if (rx_valid) begin
                case (byte_idx)
                    2'd0: begin
                        // Bit 3 is always set in a real header; anything else is noise.
                        if (rx_byte[B0_SYNC]) begin
                            hdr.left   <= rx_byte[B0_LEFT];
                            hdr.x_sign <= rx_byte[B0_XSIGN];
                            hdr.y_sign <= rx_byte[B0_YSIGN];
                            hdr.x_ovf  <= rx_byte[B0_XOVF];
                            hdr.y_ovf  <= rx_byte[B0_YOVF];
                            byte_idx   <= 2'd1;
                        end
                    end
                    2'd1: begin
                        dx_byte  <= rx_byte;
                        byte_idx <= 2'd2;
                    end
                    default: begin
                        byte_idx     <= '0;
                        mouseX       <= clamp_axis(nx, SCREEN_W);
                        mouseY       <= clamp_axis(ny, SCREEN_H);
                        mouseBotton  <= hdr.left;
                        click        <= hdr.left & ~mouseBotton;
                        packet_valid <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_cursor.sv
// Scoreboard bench for ps2_mouse_cursor: PS/2 frames driven on the pads,
// expected cursor states from an arithmetic reference model.
module tb_ps2_mouse_cursor;

    localparam int HALF = 14;
    localparam int SW   = 640;
    localparam int SH   = 480;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [9:0] mouseX, mouseY;
    logic       mouseBotton, click, packet_valid, frame_error;

    ps2_mouse_cursor dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .mouseX      (mouseX),
        .mouseY      (mouseY),
        .mouseBotton (mouseBotton),
        .click       (click),
        .packet_valid(packet_valid),
        .frame_error (frame_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int btn;
        int clk_p;
    } exp_t;

    exp_t expq[$];
    int   errors = 0, checks = 0;
    int   err_exp = 0, err_seen = 0;
    int   mx = 320, my = 240, mb = 0;
    logic pv_prev = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        cycles(HALF);
        ps2_clk = 1'b0;
        cycles(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~^b ^ bad_par);
        send_bit(1'b1);
        ps2_data = 1'b1;
        cycles(30);
    endtask

    function automatic int clampi(input int v, input int lim);
        if (v < 0) return 0;
        if (v > lim - 1) return lim - 1;
        return v;
    endfunction

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        int   dx, dy;
        exp_t e;
        dx = b0[6] ? 0 : (b0[4] ? int'(b1) - 256 : int'(b1));
        dy = b0[7] ? 0 : (b0[5] ? int'(b2) - 256 : int'(b2));
        mx = clampi(mx + dx, SW);
        my = clampi(my - dy, SH);
        e.x = mx; e.y = my; e.btn = int'(b0[0]);
        e.clk_p = (b0[0] && mb == 0) ? 1 : 0;
        mb = int'(b0[0]);
        expq.push_back(e);
        send_byte(b0, 1'b0);
        send_byte(b1, 1'b0);
        send_byte(b2, 1'b0);
    endtask

    task automatic do_reset();
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        reset    = 1'b1;
        cycles(4);
        mx = 320; my = 240; mb = 0;
        chk("reset_x", int'(mouseX), 320);
        chk("reset_y", int'(mouseY), 240);
        chk("reset_btn", int'(mouseBotton), 0);
        reset = 1'b0;
        cycles(10);
    endtask

    // Monitor: consumes expected packets whenever the DUT applies one.
    always @(negedge clk) begin
        if (frame_error) err_seen++;
        if (click && !packet_valid) begin
            checks++; errors++;
            $display("FAIL click_no_packet: click=1 while packet_valid=0");
        end
        if (packet_valid && pv_prev) begin
            checks++; errors++;
            $display("FAIL pv_width: packet_valid high 2 cycles, required 1");
        end
        if (packet_valid) begin
            if (expq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_packet: got packet at x=%0d y=%0d, required none", mouseX, mouseY);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("pkt_x", int'(mouseX), e.x);
                chk("pkt_y", int'(mouseY), e.y);
                chk("pkt_btn", int'(mouseBotton), e.btn);
                chk("pkt_click", int'(click), e.clk_p);
            end
        end
        pv_prev = packet_valid;
    end

    initial begin
        logic [7:0] b0, b1, b2;
        reset = 1'b1;
        cycles(5);
        chk("reset_x", int'(mouseX), 320);
        chk("reset_y", int'(mouseY), 240);
        chk("reset_btn", int'(mouseBotton), 0);
        chk("reset_click", int'(click), 0);
        chk("reset_pv", int'(packet_valid), 0);
        chk("reset_ferr", int'(frame_error), 0);
        reset = 1'b0;
        cycles(10);

        send_pkt(8'h08, 8'h05, 8'h03);
        send_pkt(8'h09, 8'h00, 8'h00);
        send_pkt(8'h09, 8'h00, 8'h00);
        chk("btn_held", int'(mouseBotton), 1);

        do_reset();
        for (int i = 0; i < 40; i++) send_pkt(8'h18, 8'hF6, 8'h00);
        chk("clamp_x0", int'(mouseX), 0);
        send_pkt(8'h08, 8'h7F, 8'h00);
        chk("after_clamp_x", int'(mouseX), 127);

        // Header with a wrong parity bit, then a clean packet.
        send_byte(8'h08, 1'b1);
        err_exp++;
        send_pkt(8'h08, 8'h01, 8'h01);

        // Stray non-header byte must vanish silently.
        send_byte(8'h00, 1'b0);
        send_pkt(8'h08, 8'h02, 8'h00);

        // Reset part-way through byte 1.
        send_byte(8'h08, 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(i & 1));
        do_reset();
        send_pkt(8'h08, 8'h04, 8'h00);
        chk("post_reset_x", int'(mouseX), 324);

        // Push Y into both clamps.
        for (int i = 0; i < 3; i++) send_pkt(8'h08, 8'h00, 8'h7F);
        for (int i = 0; i < 5; i++) send_pkt(8'h28, 8'h00, 8'h80);

        for (int i = 0; i < 14; i++) begin
            b1 = 8'($urandom);
            b2 = 8'($urandom);
            b0 = 8'($urandom) | 8'h08;
            if ($urandom_range(0, 5) != 0) b0[6] = 1'b0;
            if ($urandom_range(0, 5) != 0) b0[7] = 1'b0;
            if ($urandom_range(0, 4) == 0) send_byte(8'($urandom) & 8'hF7, 1'b0);
            send_pkt(b0, b1, b2);
        end

`ifdef PS2_MOUSE_WATCHDOG_EN
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        ps2_data = 1'b1;
        cycles(12000);
        err_exp++;
        send_pkt(8'h08, 8'h03, 8'h02);
`endif

        cycles(50);
        chk("queue_empty", expq.size(), 0);
        chk("frame_errors", err_seen, err_exp);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
